fetch_ctrl: RTL and testbench

//   Sequences instruction fetch: owns the program counter, issues one

---
 rtl/fetch_ctrl_if.sv | 26 ++
 rtl/fetch_ctrl.sv | 127 ++++++++++++
 tb/tb_fetch_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bus bundle: execute redirect and decode stall inputs, the
// instruction-memory req/ack port, and the decode-facing valid/instr outputs.
// The master modport is the fetch controller. The slave modport is its surroundings.
interface fetch_ctrl_if;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic [31:0] pc_o;

    modport master (
        input  stall_i, redirect_i, redirect_pc_i, mem_ack_i, mem_rdata_i,
        output mem_req_o, mem_addr_o, instr_valid_o, instr_o, instr_pc_o, pc_o
    );

    modport slave (
        output stall_i, redirect_i, redirect_pc_i, mem_ack_i, mem_rdata_i,
        input  mem_req_o, mem_addr_o, instr_valid_o, instr_o, instr_pc_o, pc_o
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer. It owns the PC and keeps at most one memory
// request outstanding. It hands each fetched word to decode with a
// valid/stall handshake. Execute redirects replace sequential PC+STEP flow.
// A redirect that arrives while a request is in flight waits in DRAIN. The
// stale response is absorbed there, and then the new target is requested.
module fetch_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] PC_STEP      = 32'd4
) (
    input  logic         clk,
    input  logic         reset,
    fetch_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2,
        ISSUE = 2'd3
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;          // architectural next-fetch PC
    logic [31:0] req_addr_q;    // address of the request on the bus
    logic        req_q;
    logic        valid_q;
    logic [31:0] instr_q;
    logic [31:0] instr_pc_q;

    logic [31:0] pc_seq_d;      // sequential successor of pc_q
    logic [31:0] redirect_tgt_d;

    // Next-address arithmetic. Redirect targets are word aligned, and the sequential step wraps modulo 2^32.
    always_comb begin
        pc_seq_d       = pc_q + PC_STEP;
        redirect_tgt_d = bus.redirect_pc_i & 32'hFFFF_FFFC;
    end

    // Fetch FSM. All outputs are registered, so decode and memory see clean signals.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VECTOR;
            req_addr_q <= RESET_VECTOR;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
            instr_q    <= 32'h0;
            instr_pc_q <= 32'h0;
        end else begin
            case (state_q)
                BOOT: begin
                    // Any ack seen here belongs to a request abandoned by reset.
                    state_q <= REQ;
                    req_q   <= 1'b1;
                    if (bus.redirect_i) begin
                        pc_q       <= redirect_tgt_d;
                        req_addr_q <= redirect_tgt_d;
                    end else begin
                        req_addr_q <= pc_q;
                    end
                end

                REQ: begin
                    if (bus.mem_ack_i && !bus.redirect_i) begin
                        instr_q    <= bus.mem_rdata_i;
                        instr_pc_q <= pc_q;
                        pc_q       <= pc_seq_d;
                        valid_q    <= 1'b1;
                        req_q      <= 1'b0;
                        state_q    <= ISSUE;
                    end else if (bus.mem_ack_i && bus.redirect_i) begin
                        // The response is on the wrong path. Start the new target at once.
                        pc_q       <= redirect_tgt_d;
                        req_addr_q <= redirect_tgt_d;
                    end else if (bus.redirect_i) begin
                        // Keep the in-flight address on the bus until memory answers.
                        pc_q    <= redirect_tgt_d;
                        state_q <= DRAIN;
                    end
                end

                DRAIN: begin
                    if (bus.mem_ack_i) begin
                        // Discard the stale word. The next request goes to the latest target.
                        state_q    <= REQ;
                        pc_q       <= bus.redirect_i ? redirect_tgt_d : pc_q;
                        req_addr_q <= bus.redirect_i ? redirect_tgt_d : pc_q;
                    end else if (bus.redirect_i) begin
                        pc_q <= redirect_tgt_d;
                    end
                end

                ISSUE: begin
                    if (bus.redirect_i) begin
                        valid_q    <= 1'b0;
                        pc_q       <= redirect_tgt_d;
                        req_addr_q <= redirect_tgt_d;
                        req_q      <= 1'b1;
                        state_q    <= REQ;
                    end else if (!bus.stall_i) begin
                        valid_q    <= 1'b0;
                        req_addr_q <= pc_q;
                        req_q      <= 1'b1;
                        state_q    <= REQ;
                    end
                end

                default: begin
                    state_q <= BOOT;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Drive the bus outputs from the registers.
    always_comb begin
        bus.mem_req_o     = req_q;
        bus.mem_addr_o    = req_addr_q;
        bus.instr_valid_o = valid_q;
        bus.instr_o       = instr_q;
        bus.instr_pc_o    = instr_pc_q;
        bus.pc_o          = pc_q;
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl. The bench plays the memory port itself.
// For every ack that should yield a word, it pushes the expected
// {pc, word} to a scoreboard. A negedge monitor pops the scoreboard on
// each new valid word and compares it with the DUT output.
module tb_fetch_ctrl;

    logic clk = 1'b0;
    logic reset;

    fetch_ctrl_if bus();

    fetch_ctrl #(
        .RESET_VECTOR(32'h0000_0000),
        .PC_STEP     (32'd4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [63:0] sb_q[$];
    logic        prev_hold = 1'b0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold a request for wait_cycles without ack, then ack it. The task ends
    // in the cycle where the word is presented to decode.
    task automatic req_ack(input logic [31:0] a, input int wait_cycles);
        for (int i = 0; i < wait_cycles; i++) begin
            chk("req_wait", 32'(bus.mem_req_o), 32'd1);
            chk("addr_wait", bus.mem_addr_o, a);
            chk("valid_wait", 32'(bus.instr_valid_o), 32'd0);
            tick();
        end
        chk("req", 32'(bus.mem_req_o), 32'd1);
        chk("addr", bus.mem_addr_o, a);
        chk("valid_in_req", 32'(bus.instr_valid_o), 32'd0);
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = word_of(a);
        sb_q.push_back({a, word_of(a)});
        tick();
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = 32'h0;
        chk("valid", 32'(bus.instr_valid_o), 32'd1);
        chk("req_in_issue", 32'(bus.mem_req_o), 32'd0);
        chk("pc_next", bus.pc_o, a + 32'd4);
    endtask

    // Decode consumes the word. Valid must drop, and the next request starts.
    task automatic consume(input logic [31:0] next_a);
        tick();
        chk("valid_drop", 32'(bus.instr_valid_o), 32'd0);
        chk("req_next", 32'(bus.mem_req_o), 32'd1);
        chk("addr_next", bus.mem_addr_o, next_a);
    endtask

    // Scoreboard monitor. A valid cycle carries a new word unless the previous cycle held a stalled word.
    always @(negedge clk) begin
        logic [63:0] e;
        if (bus.instr_valid_o && !prev_hold) begin
            n_assert++;
            assert (sb_q.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_valid observed pc=%h expected no word", bus.instr_pc_o);
            end
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("instr_pc", bus.instr_pc_o, e[63:32]);
                chk("instr", bus.instr_o, e[31:0]);
                $display("fetch pc=%h instr=%h", bus.instr_pc_o, bus.instr_o);
            end
        end
        prev_hold <= bus.instr_valid_o && bus.stall_i && !bus.redirect_i;
    end

    initial begin
        reset             = 1'b0;
        bus.stall_i       = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = 32'h0;
        bus.mem_ack_i     = 1'b0;
        bus.mem_rdata_i   = 32'h0;
        tick();
        tick();
        chk("rst_req", 32'(bus.mem_req_o), 32'd0);
        chk("rst_valid", 32'(bus.instr_valid_o), 32'd0);
        chk("rst_instr", bus.instr_o, 32'h0);
        chk("rst_instr_pc", bus.instr_pc_o, 32'h0);
        chk("rst_pc", bus.pc_o, 32'h0);

        // The first request appears one cycle after reset is released.
        reset = 1'b1;
        tick();

        // With an ack on every request, valid appears every second cycle.
        req_ack(32'h0, 0);
        consume(32'h4);
        req_ack(32'h4, 0);
        consume(32'h8);
        req_ack(32'h8, 0);
        consume(32'hC);

        // The ack comes 3 cycles late. The request stays high for 4 cycles at a stable address.
        req_ack(32'hC, 3);
        consume(32'h10);

        // Decode stalls for 5 cycles. The word is held, and no request is made.
        req_ack(32'h10, 0);
        bus.stall_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", 32'(bus.instr_valid_o), 32'd1);
            chk("stall_instr", bus.instr_o, word_of(32'h10));
            chk("stall_instr_pc", bus.instr_pc_o, 32'h10);
            chk("stall_req", 32'(bus.mem_req_o), 32'd0);
        end
        bus.stall_i = 1'b0;
        consume(32'h14);

        // A redirect arrives while the request is unacked, so the FSM drains the old request.
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h0000_0103;
        tick();
        bus.redirect_i = 1'b0;
        chk("drain_pc", bus.pc_o, 32'h100);
        chk("drain_addr", bus.mem_addr_o, 32'h14);
        chk("drain_req", 32'(bus.mem_req_o), 32'd1);
        tick();
        chk("drain_addr_hold", bus.mem_addr_o, 32'h14);
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = 32'hDEAD_BEEF;   // stale word, no push
        tick();
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = 32'h0;
        chk("post_drain_valid", 32'(bus.instr_valid_o), 32'd0);
        req_ack(32'h100, 0);
        consume(32'h104);

        // Redirect and stall arrive together in ISSUE. The redirect wins.
        req_ack(32'h104, 0);
        bus.stall_i       = 1'b1;
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h0000_0200;
        tick();
        bus.stall_i    = 1'b0;
        bus.redirect_i = 1'b0;
        chk("redir_issue_valid", 32'(bus.instr_valid_o), 32'd0);
        chk("redir_issue_req", 32'(bus.mem_req_o), 32'd1);
        chk("redir_issue_addr", bus.mem_addr_o, 32'h200);

        // A redirect arrives with the ack. The data is dropped, and the target is the top word, which wraps.
        bus.mem_ack_i     = 1'b1;
        bus.mem_rdata_i   = 32'h0BAD_0BAD;
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'hFFFF_FFFF;
        tick();
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = 32'h0;
        bus.redirect_i  = 1'b0;
        chk("ackredir_valid", 32'(bus.instr_valid_o), 32'd0);
        req_ack(32'hFFFF_FFFC, 0);
        consume(32'h0000_0000);
        req_ack(32'h0000_0000, 1);
        consume(32'h4);

        // Reset mid-request. The late ack is ignored, and a redirect in BOOT is taken.
        reset = 1'b0;
        tick();
        chk("midrst_req", 32'(bus.mem_req_o), 32'd0);
        chk("midrst_pc", bus.pc_o, 32'h0);
        reset             = 1'b1;
        bus.mem_ack_i     = 1'b1;
        bus.mem_rdata_i   = 32'h5555_AAAA;
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h0000_0302;
        tick();
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = 32'h0;
        bus.redirect_i  = 1'b0;
        chk("boot_valid", 32'(bus.instr_valid_o), 32'd0);
        chk("boot_pc", bus.pc_o, 32'h300);
        req_ack(32'h300, 0);
        consume(32'h304);
        tick();

        n_assert++;
        assert (sb_q.size() == 0) else begin
            n_fail++;
            $error("FAIL sb_empty observed=%0d expected=0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
